// File: rtl/mem_stage.sv
// mem_stage: MEM/WB stage downstream of execute.
// A memory op is accepted from EX, run as a req/ack bus transaction while
// the front of the pipeline is stalled, then its result is written back
// through the registered register-file write port. Non-memory instructions
// pass their writeback value straight through with one cycle of latency.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_memctrl_vld,
  input  logic        i_memctrl_wr,
  input  logic        i_memctrl_sign,
  input  logic [1:0]  i_memctrl_size,
  input  logic [31:0] i_memctrl_addr,
  input  logic [31:0] i_memctrl_wdata,
  input  logic [31:0] i_wb_op,
  input  logic        i_wb_rd_src,
  input  logic        i_wb_rd_vld,
  input  logic [3:0]  i_wb_rd_code,
  output logic        o_stall,
  output logic        o_bus_req,
  output logic        o_bus_wr,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ack,
  output logic        o_rd_en_wb,
  output logic [3:0]  o_rd_code_wb,
  output logic [31:0] o_rd_reg_wb,
  output logic        o_data_abort
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_wr_q, bus_wr_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        lat_sign_q, lat_sign_d;
  logic [1:0]  lat_size_q, lat_size_d;
  logic [1:0]  lat_ofs_q, lat_ofs_d;
  logic [31:0] lat_wb_op_q, lat_wb_op_d;
  logic        lat_src_q, lat_src_d;
  logic        lat_rd_vld_q, lat_rd_vld_d;
  logic [3:0]  lat_code_q, lat_code_d;
  logic        rd_en_q, rd_en_d;
  logic [3:0]  rd_code_q, rd_code_d;
  logic [31:0] rd_reg_q, rd_reg_d;
  logic        data_abort_q, data_abort_d;

  logic [31:0] load_data;
  logic        timeout_hit;

  // Byte enables for a store of the given size at byte offset ofs.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] ofs);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << ofs;
      2'b01:   be = ofs[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate low-aligned store data across every lane it could land in.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] wd;
    case (size)
      2'b00:   wd = {4{wdata[7:0]}};
      2'b01:   wd = {2{wdata[15:0]}};
      default: wd = wdata;
    endcase
    return wd;
  endfunction

  // ARMv4 load alignment: lane pick plus extension, or rotation for words.
  function automatic logic [31:0] load_align(input logic [1:0]  size,
                                             input logic        sign,
                                             input logic [1:0]  ofs,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [5:0]  sh;
    logic [31:0] res;
    b  = rdata[{ofs, 3'b000} +: 8];
    h  = rdata[{ofs[1], 4'b0000} +: 16];
    sh = {1'b0, ofs, 3'b000};
    case (size)
      2'b00:   res = {{24{sign & b[7]}}, b};
      2'b01:   res = {{16{sign & h[15]}}, h};
      default: res = (rdata >> sh) | (rdata << (6'd32 - sh));
    endcase
    return res;
  endfunction

  assign load_data   = load_align(lat_size_q, lat_sign_q, lat_ofs_q, i_bus_rdata);
  assign timeout_hit = (TIMEOUT != 0) && (({1'b0, tmo_cnt_q} + 17'd1) == 17'(TIMEOUT));

  // Next-state and next-output logic for the IDLE -> BUS -> WB sequence.
  always_comb begin
    // NOTE: every _d gets a default first, so no branch can leave one unassigned and infer a latch.
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    lat_sign_d   = lat_sign_q;
    lat_size_d   = lat_size_q;
    lat_ofs_d    = lat_ofs_q;
    lat_wb_op_d  = lat_wb_op_q;
    lat_src_d    = lat_src_q;
    lat_rd_vld_d = lat_rd_vld_q;
    lat_code_d   = lat_code_q;
    rd_en_d      = rd_en_q;
    rd_code_d    = rd_code_q;
    rd_reg_d     = rd_reg_q;
    data_abort_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_memctrl_vld) begin
          state_d      = S_BUS;
          tmo_cnt_d    = '0;
          bus_req_d    = 1'b1;
          bus_wr_d     = i_memctrl_wr;
          bus_addr_d   = {i_memctrl_addr[31:2], 2'b00};
          bus_be_d     = i_memctrl_wr ? store_be(i_memctrl_size, i_memctrl_addr[1:0]) : 4'b1111;
          bus_wdata_d  = store_wdata(i_memctrl_size, i_memctrl_wdata);
          lat_sign_d   = i_memctrl_sign;
          lat_size_d   = i_memctrl_size;
          lat_ofs_d    = i_memctrl_addr[1:0];
          lat_wb_op_d  = i_wb_op;
          lat_src_d    = i_wb_rd_src;
          lat_rd_vld_d = i_wb_rd_vld;
          lat_code_d   = i_wb_rd_code;
          rd_en_d      = 1'b0;
        end else begin
          rd_en_d   = i_wb_rd_vld;
          rd_code_d = i_wb_rd_code;
          rd_reg_d  = i_wb_op;
        end
      end
      S_BUS: begin
        if (bus_req_q && i_bus_ack) begin
          state_d   = S_WB;
          bus_req_d = 1'b0;
          rd_en_d   = lat_rd_vld_q;
          rd_code_d = lat_code_q;
          // Stores only ever write the pass-through value.
          rd_reg_d  = (!bus_wr_q && lat_src_q) ? load_data : lat_wb_op_q;
        end else if (timeout_hit) begin
          state_d      = S_WB;
          bus_req_d    = 1'b0;
          data_abort_d = 1'b1;
          rd_en_d      = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      S_WB: begin
        // EX still shows the finished memory instruction this cycle, so a
        // memory request here is the same one and must not restart.
        state_d = S_IDLE;
        if (!i_memctrl_vld) begin
          rd_en_d   = i_wb_rd_vld;
          rd_code_d = i_wb_rd_code;
          rd_reg_d  = i_wb_op;
        end else begin
          rd_en_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: every flop here is control or datapath state that must read 0 out of reset, so all are reset; <= keeps updates order-independent.
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      tmo_cnt_q    <= '0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
      lat_sign_q   <= 1'b0;
      lat_size_q   <= '0;
      lat_ofs_q    <= '0;
      lat_wb_op_q  <= '0;
      lat_src_q    <= 1'b0;
      lat_rd_vld_q <= 1'b0;
      lat_code_q   <= '0;
      rd_en_q      <= 1'b0;
      rd_code_q    <= '0;
      rd_reg_q     <= '0;
      data_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      lat_sign_q   <= lat_sign_d;
      lat_size_q   <= lat_size_d;
      lat_ofs_q    <= lat_ofs_d;
      lat_wb_op_q  <= lat_wb_op_d;
      lat_src_q    <= lat_src_d;
      lat_rd_vld_q <= lat_rd_vld_d;
      lat_code_q   <= lat_code_d;
      rd_en_q      <= rd_en_d;
      rd_code_q    <= rd_code_d;
      rd_reg_q     <= rd_reg_d;
      data_abort_q <= data_abort_d;
    end
  end

  // Stall is combinational so EX freezes in the very cycle an op is accepted;
  // gating with reset keeps every output low while reset is held.
  assign o_stall      = i_rst_n & (((state_q == S_IDLE) & i_memctrl_vld) | (state_q == S_BUS));
  assign o_bus_req    = bus_req_q;
  assign o_bus_wr     = bus_wr_q;
  assign o_bus_addr   = bus_addr_q;
  assign o_bus_be     = bus_be_q;
  assign o_bus_wdata  = bus_wdata_q;
  assign o_rd_en_wb   = rd_en_q;
  assign o_rd_code_wb = rd_code_q;
  assign o_rd_reg_wb  = rd_reg_q;
  assign o_data_abort = data_abort_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed cases plus randomized traffic checked
// against a lane/extension model written directly from the byte rules.
module tb_mem_stage;

  localparam int unsigned TMO_MAIN  = 8;
  localparam int unsigned TMO_SHORT = 3;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_memctrl_vld, i_memctrl_wr, i_memctrl_sign;
  logic [1:0]  i_memctrl_size;
  logic [31:0] i_memctrl_addr, i_memctrl_wdata, i_wb_op;
  logic        i_wb_rd_src, i_wb_rd_vld;
  logic [3:0]  i_wb_rd_code;
  logic [31:0] i_bus_rdata;
  logic        i_bus_ack;

  logic        o_stall, o_bus_req, o_bus_wr, o_rd_en_wb, o_data_abort;
  logic [31:0] o_bus_addr, o_bus_wdata, o_rd_reg_wb;
  logic [3:0]  o_bus_be, o_rd_code_wb;

  logic        s_stall, s_bus_req, s_bus_wr, s_rd_en_wb, s_data_abort;
  logic [31:0] s_bus_addr, s_bus_wdata, s_rd_reg_wb;
  logic [3:0]  s_bus_be, s_rd_code_wb;

  int n_checks;
  int n_fail;

  mem_stage #(.TIMEOUT(TMO_MAIN)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_memctrl_vld(i_memctrl_vld), .i_memctrl_wr(i_memctrl_wr), .i_memctrl_sign(i_memctrl_sign),
    .i_memctrl_size(i_memctrl_size), .i_memctrl_addr(i_memctrl_addr), .i_memctrl_wdata(i_memctrl_wdata),
    .i_wb_op(i_wb_op), .i_wb_rd_src(i_wb_rd_src), .i_wb_rd_vld(i_wb_rd_vld), .i_wb_rd_code(i_wb_rd_code),
    .o_stall(o_stall), .o_bus_req(o_bus_req), .o_bus_wr(o_bus_wr), .o_bus_addr(o_bus_addr),
    .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata), .i_bus_rdata(i_bus_rdata), .i_bus_ack(i_bus_ack),
    .o_rd_en_wb(o_rd_en_wb), .o_rd_code_wb(o_rd_code_wb), .o_rd_reg_wb(o_rd_reg_wb),
    .o_data_abort(o_data_abort)
  );

  mem_stage #(.TIMEOUT(TMO_SHORT)) dut_short (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_memctrl_vld(i_memctrl_vld), .i_memctrl_wr(i_memctrl_wr), .i_memctrl_sign(i_memctrl_sign),
    .i_memctrl_size(i_memctrl_size), .i_memctrl_addr(i_memctrl_addr), .i_memctrl_wdata(i_memctrl_wdata),
    .i_wb_op(i_wb_op), .i_wb_rd_src(i_wb_rd_src), .i_wb_rd_vld(i_wb_rd_vld), .i_wb_rd_code(i_wb_rd_code),
    .o_stall(s_stall), .o_bus_req(s_bus_req), .o_bus_wr(s_bus_wr), .o_bus_addr(s_bus_addr),
    .o_bus_be(s_bus_be), .o_bus_wdata(s_bus_wdata), .i_bus_rdata(i_bus_rdata), .i_bus_ack(i_bus_ack),
    .o_rd_en_wb(s_rd_en_wb), .o_rd_code_wb(s_rd_code_wb), .o_rd_reg_wb(s_rd_reg_wb),
    .o_data_abort(s_data_abort)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_be(input logic wr, input logic [1:0] size, input logic [1:0] a);
    if (!wr || size >= 2) return 4'hF;
    if (size == 0) return 4'(1 << a);
    return (a >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 0) return 32'(wd[7:0]) * 32'h0101_0101;
    if (size == 1) return 32'(wd[15:0]) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic sign,
                                         input logic [1:0] a, input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    logic [63:0] two;
    int          sh;
    sh = int'(a) * 8;
    if (size == 0) begin
      b = r[sh +: 8];
      return (sign && b[7]) ? (32'hFFFF_FF00 | 32'(b)) : 32'(b);
    end
    if (size == 1) begin
      h = (a >= 2) ? r[31:16] : r[15:0];
      return (sign && h[15]) ? (32'hFFFF_0000 | 32'(h)) : 32'(h);
    end
    two = {r, r};
    two = two >> sh;
    return two[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_ex(input logic vld, input logic wr, input logic sign, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] wb_op,
                          input logic src, input logic rd_vld, input logic [3:0] code);
    i_memctrl_vld   = vld;
    i_memctrl_wr    = wr;
    i_memctrl_sign  = sign;
    i_memctrl_size  = size;
    i_memctrl_addr  = addr;
    i_memctrl_wdata = wdata;
    i_wb_op         = wb_op;
    i_wb_rd_src     = src;
    i_wb_rd_vld     = rd_vld;
    i_wb_rd_code    = code;
  endtask

  // One full memory transaction against the main DUT; starts just after a
  // rising edge with the stage idle and ends just after the WB edge.
  task automatic do_mem_op(input logic wr, input logic sign, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] wb_op,
                           input logic src, input logic rd_vld, input logic [3:0] code,
                           input int delay, input logic [31:0] rdata,
                           output logic [3:0] got_be, output logic [31:0] got_bwdata,
                           output logic got_en, output logic [31:0] got_reg,
                           output int n_stall, output int n_req);
    logic [31:0] exp_addr, exp_wd, exp_reg;
    logic [3:0]  exp_be;
    exp_addr   = addr & 32'hFFFF_FFFC;
    exp_be     = m_be(wr, size, addr[1:0]);
    exp_wd     = m_wdata(size, wdata);
    exp_reg    = (!wr && src) ? m_load(size, sign, addr[1:0], rdata) : wb_op;
    n_stall    = 0;
    n_req      = 0;
    got_be     = '0;
    got_bwdata = '0;
    drive_ex(1'b1, wr, sign, size, addr, wdata, wb_op, src, rd_vld, code);
    i_bus_ack   = 1'b0;
    i_bus_rdata = $urandom;
    @(negedge i_clk);
    n_checks++;
    if (o_stall !== 1'b1) begin n_fail++; $display("FAIL accept_stall: got %b want 1", o_stall); end
    if (o_stall === 1'b1) n_stall++;
    n_checks++;
    if (o_bus_req !== 1'b0) begin n_fail++; $display("FAIL accept_req: got %b want 0", o_bus_req); end
    @(posedge i_clk); #1;
    n_checks++;
    if (o_rd_en_wb !== 1'b0) begin n_fail++; $display("FAIL accept_rd_en: got %b want 0", o_rd_en_wb); end
    for (int k = 0; k <= delay; k++) begin
      i_bus_ack   = (k == delay);
      i_bus_rdata = (k == delay) ? rdata : $urandom;
      @(negedge i_clk);
      if (o_stall === 1'b1) n_stall++;
      if (o_bus_req === 1'b1) n_req++;
      got_be     = o_bus_be;
      got_bwdata = o_bus_wdata;
      n_checks++;
      if (o_bus_req !== 1'b1 || o_stall !== 1'b1) begin
        n_fail++; $display("FAIL bus_req_stall: got req=%b stall=%b want 1/1", o_bus_req, o_stall);
      end
      n_checks++;
      if (o_bus_addr !== exp_addr || o_bus_wr !== wr) begin
        n_fail++; $display("FAIL bus_addr_wr: got %h/%b want %h/%b", o_bus_addr, o_bus_wr, exp_addr, wr);
      end
      n_checks++;
      if (o_bus_be !== exp_be) begin n_fail++; $display("FAIL bus_be: got %b want %b", o_bus_be, exp_be); end
      if (wr) begin
        n_checks++;
        if (o_bus_wdata !== exp_wd) begin
          n_fail++; $display("FAIL bus_wdata: got %h want %h", o_bus_wdata, exp_wd);
        end
      end
      @(posedge i_clk); #1;
    end
    i_bus_ack   = 1'b0;
    i_bus_rdata = $urandom;
    // WB cycle: EX keeps presenting the same memory instruction.
    @(negedge i_clk);
    got_en  = o_rd_en_wb;
    got_reg = o_rd_reg_wb;
    if (o_stall === 1'b1) n_stall++;
    n_checks++;
    if (o_stall !== 1'b0 || o_bus_req !== 1'b0 || o_data_abort !== 1'b0) begin
      n_fail++; $display("FAIL wb_ctrl: got stall=%b req=%b abort=%b want 0/0/0", o_stall, o_bus_req, o_data_abort);
    end
    n_checks++;
    if (o_rd_en_wb !== rd_vld) begin n_fail++; $display("FAIL wb_rd_en: got %b want %b", o_rd_en_wb, rd_vld); end
    if (rd_vld) begin
      n_checks++;
      if (o_rd_code_wb !== code || o_rd_reg_wb !== exp_reg) begin
        n_fail++; $display("FAIL wb_data: got r%0d=%h want r%0d=%h", o_rd_code_wb, o_rd_reg_wb, code, exp_reg);
      end
    end
    @(posedge i_clk); #1;
    n_checks++;
    if (o_rd_en_wb !== 1'b0) begin n_fail++; $display("FAIL wb_ignore_vld: got rd_en %b want 0", o_rd_en_wb); end
  endtask

  // One non-memory instruction through the pass-through path.
  task automatic do_nonmem(input logic [31:0] wb_op, input logic [3:0] code, input logic rd_vld,
                           input logic ack);
    drive_ex(1'b0, 1'(($urandom)), 1'(($urandom)), 2'($urandom), $urandom, $urandom, wb_op,
             1'($urandom), rd_vld, code);
    i_bus_ack   = ack;
    i_bus_rdata = $urandom;
    @(negedge i_clk);
    n_checks++;
    if (o_stall !== 1'b0 || o_bus_req !== 1'b0 || o_data_abort !== 1'b0) begin
      n_fail++; $display("FAIL nonmem_ctrl: got stall=%b req=%b abort=%b want 0/0/0", o_stall, o_bus_req, o_data_abort);
    end
    @(posedge i_clk); #1;
    n_checks++;
    if (o_rd_en_wb !== rd_vld || o_rd_code_wb !== code || o_rd_reg_wb !== wb_op) begin
      n_fail++; $display("FAIL nonmem_wb: got %b r%0d=%h want %b r%0d=%h",
                         o_rd_en_wb, o_rd_code_wb, o_rd_reg_wb, rd_vld, code, wb_op);
    end
    i_bus_ack = 1'b0;
  endtask

  task automatic apply_reset();
    drive_ex(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, 4'd0);
    i_bus_ack   = 1'b0;
    i_bus_rdata = '0;
    i_rst_n     = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_ex(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, 4'd0);
    i_bus_ack   = 1'b0;
    i_bus_rdata = '0;
    i_rst_n     = 1'b0;
    #12;
    n_checks++;
    if ({o_stall, o_bus_req, o_bus_wr, o_bus_addr, o_bus_be, o_bus_wdata,
         o_rd_en_wb, o_rd_code_wb, o_rd_reg_wb, o_data_abort} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got req=%b be=%b rd_en=%b reg=%h want all 0",
                         o_bus_req, o_bus_be, o_rd_en_wb, o_rd_reg_wb);
    end
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    n_checks++;
    if (o_rd_en_wb !== 1'b0 || o_bus_req !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got rd_en=%b req=%b want 0/0", o_rd_en_wb, o_bus_req);
    end
  endtask

  task automatic test_nonmem();
    // BL-style link write, then random pass-through traffic.
    do_nonmem(32'h0000_8004, 4'd14, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) do_nonmem($urandom, 4'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic test_directed();
    logic [3:0]  be;
    logic [31:0] bwd, rg;
    logic        en;
    int          ns, nr;
    // Signed LDRB from the top lane.
    do_mem_op(1'b0, 1'b1, 2'b00, 32'h1003, 32'h0, 32'h5555_0000, 1'b1, 1'b1, 4'd2, 0, 32'h80FF_1234,
              be, bwd, en, rg, ns, nr);
    n_checks++;
    if (be !== 4'hF || rg !== 32'hFFFF_FF80 || ns != 2 || en !== 1'b1) begin
      n_fail++; $display("FAIL ldrb_signed: got be=%b r2=%h stall=%0d want 1111 ffffff80 2", be, rg, ns);
    end
    // Unaligned word load rotates.
    do_mem_op(1'b0, 1'b1, 2'b10, 32'h1001, 32'h0, 32'h0, 1'b1, 1'b1, 4'd3, 1, 32'h1122_3344,
              be, bwd, en, rg, ns, nr);
    n_checks++;
    if (rg !== 32'h4411_2233) begin n_fail++; $display("FAIL ldr_rotate: got %h want 44112233", rg); end
    // Upper halfword, zero-extended.
    do_mem_op(1'b0, 1'b0, 2'b01, 32'h1002, 32'h0, 32'h0, 1'b1, 1'b1, 4'd4, 0, 32'h1122_3344,
              be, bwd, en, rg, ns, nr);
    n_checks++;
    if (rg !== 32'h0000_1122) begin n_fail++; $display("FAIL ldrh_upper: got %h want 00001122", rg); end
    // STRH to the upper half with no register write.
    do_mem_op(1'b1, 1'b0, 2'b01, 32'h2002, 32'h0000_ABCD, 32'h0, 1'b0, 1'b0, 4'd5, 0, 32'h0,
              be, bwd, en, rg, ns, nr);
    n_checks++;
    if (be !== 4'b1100 || bwd !== 32'hABCD_ABCD || en !== 1'b0) begin
      n_fail++; $display("FAIL strh: got be=%b wdata=%h rd_en=%b want 1100 abcdabcd 0", be, bwd, en);
    end
  endtask

  task automatic test_ack_delay();
    logic [3:0]  be;
    logic [31:0] bwd, rg;
    logic        en;
    int          ns, nr;
    do_mem_op(1'b0, 1'b0, 2'b00, 32'h3002, 32'h0, 32'h0, 1'b1, 1'b1, 4'd7, 4, 32'hDEAD_BEEF,
              be, bwd, en, rg, ns, nr);
    n_checks++;
    if (nr != 5 || ns != 6) begin
      n_fail++; $display("FAIL ack_delay_counts: got req=%0d stall=%0d want 5 6", nr, ns);
    end
    // Ack while idle must not start or disturb anything.
    for (int i = 0; i < 3; i++) do_nonmem($urandom, 4'($urandom), 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  be;
    logic [31:0] bwd, rg;
    logic        en;
    int          ns, nr;
    do_mem_op(1'b1, 1'b0, 2'b00, 32'h4001, 32'h0000_00A5, 32'h1234, 1'b0, 1'b1, 4'd8, 0, 32'h0,
              be, bwd, en, rg, ns, nr);
    n_checks++;
    if (be !== 4'b0010 || bwd !== 32'hA5A5_A5A5 || en !== 1'b1 || rg !== 32'h1234) begin
      n_fail++; $display("FAIL strb_link: got be=%b wd=%h en=%b reg=%h want 0010 a5a5a5a5 1 1234", be, bwd, en, rg);
    end
    do_mem_op(1'b0, 1'b1, 2'b01, 32'h4000, 32'h0, 32'h0, 1'b1, 1'b1, 4'd9, 2, 32'h0000_8001,
              be, bwd, en, rg, ns, nr);
    n_checks++;
    if (rg !== 32'hFFFF_8001) begin n_fail++; $display("FAIL ldrsh_b2b: got %h want ffff8001", rg); end
  endtask

  task automatic test_random();
    logic [3:0]  be;
    logic [31:0] bwd, rg;
    logic        en;
    int          ns, nr;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_nonmem($urandom, 4'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        do_mem_op(1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                  1'($urandom), 1'($urandom), 4'($urandom), $urandom_range(0, 3), $urandom,
                  be, bwd, en, rg, ns, nr);
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    drive_ex(1'b1, 1'b0, 1'b0, 2'b10, 32'h5000, 32'h0, 32'h77, 1'b1, 1'b1, 4'd6);
    i_bus_ack = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if (s_stall !== 1'b1) begin n_fail++; $display("FAIL tmo_accept: got stall %b want 1", s_stall); end
    @(posedge i_clk); #1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_clk);
      n_checks++;
      if (s_bus_req !== 1'b1 || s_data_abort !== 1'b0) begin
        n_fail++; $display("FAIL tmo_wait%0d: got req=%b abort=%b want 1/0", k, s_bus_req, s_data_abort);
      end
      @(posedge i_clk); #1;
    end
    @(negedge i_clk);
    n_checks++;
    if (s_bus_req !== 1'b0 || s_data_abort !== 1'b1 || s_rd_en_wb !== 1'b0 || s_stall !== 1'b0) begin
      n_fail++; $display("FAIL tmo_abort: got req=%b abort=%b rd_en=%b stall=%b want 0/1/0/0",
                         s_bus_req, s_data_abort, s_rd_en_wb, s_stall);
    end
    n_checks++;
    if (o_bus_req !== 1'b1 || o_data_abort !== 1'b0) begin
      n_fail++; $display("FAIL tmo_long_still_waiting: got req=%b abort=%b want 1/0", o_bus_req, o_data_abort);
    end
    @(posedge i_clk); #1;
    @(negedge i_clk);
    n_checks++;
    if (s_data_abort !== 1'b0 || s_rd_en_wb !== 1'b0) begin
      n_fail++; $display("FAIL tmo_pulse_len: got abort=%b rd_en=%b want 0/0", s_data_abort, s_rd_en_wb);
    end
    // Reset in the middle of the long DUT's bus wait, away from any edge.
    @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_stall, o_bus_req, o_bus_wr, o_bus_addr, o_bus_be, o_bus_wdata,
         o_rd_en_wb, o_rd_code_wb, o_rd_reg_wb, o_data_abort} !== '0) begin
      n_fail++; $display("FAIL reset_mid_bus: got stall=%b req=%b addr=%h be=%b want all 0",
                         o_stall, o_bus_req, o_bus_addr, o_bus_be);
    end
    i_memctrl_vld = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_nonmem();
    test_directed();
    test_ack_delay();
    test_back_to_back();
    test_random();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
